// File: rtl/fb_swap_ctrl_pkg.sv
// lava_pkg: shared constants and types for the LED panel frame-buffer slice.
//   FB_ADDR_W  - pixel address width per panel half (64 cols x 16 rows)
//   PIXEL_W    - RGB444 pixel width
//   PANEL_ROWS - scan rows per half
//   fb_state_t - frame-buffer swap controller states
//   pixel_t    - one RGB444 pixel
package lava_pkg;

    localparam int FB_ADDR_W  = 10;
    localparam int PIXEL_W    = 12;
    localparam int PANEL_ROWS = 16;

    typedef enum logic [1:0] {
        FB_IDLE,
        FB_SWAP_PEND,
        FB_CLEAR
    } fb_state_t;

    typedef logic [PIXEL_W-1:0] pixel_t;

endpackage

// File: rtl/fb_swap_ctrl_if.sv
// fb_swap_ctrl_if: display read port, renderer write handshake and swap
// control of the frame-buffer manager.
//   slave  - the frame-buffer controller
//   master - the display controller / renderer side
// Signals:
//   disp_addr, disp_top, disp_btm : display read address and registered pixels
//   row_sel                       : current display scan row
//   wr_valid, wr_ready            : renderer write handshake
//   wr_addr, wr_data              : {half, pixel address} and write pixel
//   swap_req, clear_on_swap       : swap request and clear-after-swap option
//   swap_ack, front, busy         : swap pulse, front bank, controller busy
interface fb_swap_ctrl_if #(
    parameter int ADDR_W  = 10,
    parameter int PIXEL_W = 12,
    parameter int ROW_W   = 4
);
    logic [ADDR_W-1:0]  disp_addr;
    logic [PIXEL_W-1:0] disp_top;
    logic [PIXEL_W-1:0] disp_btm;
    logic [ROW_W-1:0]   row_sel;
    logic               wr_valid;
    logic               wr_ready;
    logic [ADDR_W:0]    wr_addr;
    logic [PIXEL_W-1:0] wr_data;
    logic               swap_req;
    logic               clear_on_swap;
    logic               swap_ack;
    logic               front;
    logic               busy;

    modport slave (
        input  disp_addr, row_sel, wr_valid, wr_addr, wr_data, swap_req, clear_on_swap,
        output disp_top, disp_btm, wr_ready, swap_ack, front, busy
    );

    modport master (
        output disp_addr, row_sel, wr_valid, wr_addr, wr_data, swap_req, clear_on_swap,
        input  disp_top, disp_btm, wr_ready, swap_ack, front, busy
    );
endinterface

// File: rtl/fb_bank_ram.sv
// fb_bank_ram: simple dual-port pixel RAM, one synchronous write port and one
// synchronous read port. Contents are not reset; only the read register is.
//   clk, rst          : clock, synchronous active-high reset (read register)
//   we_i, waddr_i,
//   wdata_i           : write port
//   raddr_i, rdata_o  : read port, data registered one edge after the address
module fb_bank_ram #(
    parameter int ADDR_W  = 10,
    parameter int PIXEL_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [PIXEL_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]  raddr_i,
    output logic [PIXEL_W-1:0] rdata_o
);

    logic [PIXEL_W-1:0] mem_q [2**ADDR_W];
    logic [PIXEL_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl: double-buffered frame-buffer manager for the 64x32 RGB444 panel.
// Four RAMs (bank x half). The display reads the front bank, the renderer
// writes the back bank, and banks swap on request at the next frame wrap,
// optionally followed by a clear sweep of the new back bank.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fb_swap_ctrl_if.slave (display read, renderer write, swap control)
module fb_swap_ctrl #(
    parameter int                 ADDR_W    = 10,
    parameter int                 PIXEL_W   = 12,
    parameter int                 ROWS      = 16,
    parameter logic [PIXEL_W-1:0] CLEAR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    fb_swap_ctrl_if.slave bus
);
    import lava_pkg::*;

    localparam int ROW_W = $clog2(ROWS);

    fb_state_t         state_q, state_d;
    logic              front_q, front_d;
    logic              swap_ack_q, swap_ack_d;
    logic              clr_flag_q, clr_flag_d;
    logic [ADDR_W-1:0] clear_addr_q, clear_addr_d;
    logic [ROW_W-1:0]  prev_row_q;
    logic              front_rd_q;   // front as seen when disp_addr was sampled

    logic wrap;
    logic wr_ready;
    logic wr_fire;
    logic clearing;

    logic [1:0][1:0]              ram_we;     // [bank][half]
    logic [1:0][1:0][PIXEL_W-1:0] ram_rdata;
    logic [ADDR_W-1:0]            ram_waddr;
    logic [PIXEL_W-1:0]           ram_wdata;

    assign wrap     = (prev_row_q == ROW_W'(ROWS - 1)) && (bus.row_sel == '0);
    assign wr_ready = (state_q == FB_IDLE) && !rst;
    assign wr_fire  = bus.wr_valid && wr_ready;
    assign clearing = (state_q == FB_CLEAR);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FB_IDLE;
            front_q      <= 1'b0;
            swap_ack_q   <= 1'b0;
            clr_flag_q   <= 1'b0;
            clear_addr_q <= '0;
            prev_row_q   <= '0;
            front_rd_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            front_q      <= front_d;
            swap_ack_q   <= swap_ack_d;
            clr_flag_q   <= clr_flag_d;
            clear_addr_q <= clear_addr_d;
            prev_row_q   <= bus.row_sel;
            front_rd_q   <= front_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        front_d      = front_q;
        swap_ack_d   = 1'b0;
        clr_flag_d   = clr_flag_q;
        clear_addr_d = clear_addr_q;
        case (state_q)
            FB_IDLE: begin
                // A wrap seen in the same cycle does not count: the swap waits
                // for the following frame boundary.
                if (bus.swap_req) begin
                    state_d    = FB_SWAP_PEND;
                    clr_flag_d = bus.clear_on_swap;
                end
            end
            FB_SWAP_PEND: begin
                if (wrap) begin
                    front_d      = ~front_q;
                    swap_ack_d   = 1'b1;
                    clear_addr_d = '0;
                    state_d      = clr_flag_q ? FB_CLEAR : FB_IDLE;
                end
            end
            FB_CLEAR: begin
                // Stop on all-ones rather than waiting for rollover.
                if (clear_addr_q == '1) begin
                    state_d      = FB_IDLE;
                    clear_addr_d = '0;
                end else begin
                    clear_addr_d = clear_addr_q + 1'b1;
                end
            end
            default: state_d = FB_IDLE;
        endcase
    end

    // ---------------- RAM write muxing ----------------
    // Only the back bank (~front) is ever written, so display reads and
    // renderer/clear writes never touch the same RAM.
    always_comb begin
        ram_we    = '0;
        ram_waddr = clearing ? clear_addr_q : bus.wr_addr[ADDR_W-1:0];
        ram_wdata = clearing ? CLEAR_VAL : bus.wr_data;
        for (int b = 0; b < 2; b++) begin
            for (int h = 0; h < 2; h++) begin
                if (b[0] == ~front_q)
                    ram_we[b][h] = clearing || (wr_fire && (bus.wr_addr[ADDR_W] == h[0]));
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar h = 0; h < 2; h++) begin : g_half
            fb_bank_ram #(
                .ADDR_W  (ADDR_W),
                .PIXEL_W (PIXEL_W)
            ) u_ram (
                .clk     (clk),
                .rst     (rst),
                .we_i    (ram_we[b][h]),
                .waddr_i (ram_waddr),
                .wdata_i (ram_wdata),
                .raddr_i (bus.disp_addr),
                .rdata_o (ram_rdata[b][h])
            );
        end
    end

    // ---------------- outputs ----------------
    assign bus.disp_top = front_rd_q ? ram_rdata[1][0] : ram_rdata[0][0];
    assign bus.disp_btm = front_rd_q ? ram_rdata[1][1] : ram_rdata[0][1];
    assign bus.wr_ready = wr_ready;
    assign bus.swap_ack = swap_ack_q;
    assign bus.front    = front_q;
    assign bus.busy     = (state_q == FB_SWAP_PEND) || (state_q == FB_CLEAR);

endmodule

// File: tb/tb_fb_swap_ctrl.sv
module tb_fb_swap_ctrl;
    localparam int ADDR_W  = 10;
    localparam int PIXEL_W = 12;
    localparam int ROWS    = 16;
    localparam int ROW_W   = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fb_swap_ctrl_if #(.ADDR_W(ADDR_W), .PIXEL_W(PIXEL_W), .ROW_W(ROW_W)) bus ();

    fb_swap_ctrl #(
        .ADDR_W    (ADDR_W),
        .PIXEL_W   (PIXEL_W),
        .ROWS      (ROWS),
        .CLEAR_VAL (12'h000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [ADDR_W:0] a, input logic [PIXEL_W-1:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a,
                          input logic [PIXEL_W-1:0] top, input logic [PIXEL_W-1:0] btm);
        bus.disp_addr = a;
        step();
        chk({tag, "_top"}, 32'(bus.disp_top), 32'(top));
        chk({tag, "_btm"}, 32'(bus.disp_btm), 32'(btm));
    endtask

    // Request a swap, then present a 15 -> 0 row wrap; checks the ack pulse.
    task automatic do_swap(input logic clr, input logic exp_front);
        bus.row_sel       = 4'd5;
        bus.swap_req      = 1'b1;
        bus.clear_on_swap = clr;
        step();
        bus.swap_req      = 1'b0;
        bus.clear_on_swap = 1'b0;
        bus.row_sel       = 4'd15;
        step();
        bus.row_sel       = 4'd0;
        step();
        chk("swap_ack", 32'(bus.swap_ack), 32'd1);
        chk("swap_front", 32'(bus.front), 32'(exp_front));
        bus.row_sel = 4'd1;
        if (!clr) step();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst               = 1'b1;
        bus.disp_addr     = '0;
        bus.row_sel       = 4'd5;
        bus.wr_valid      = 1'b0;
        bus.wr_addr       = '0;
        bus.wr_data       = '0;
        bus.swap_req      = 1'b0;
        bus.clear_on_swap = 1'b0;

        // Reset
        repeat (3) step();
        chk("rst_front", 32'(bus.front), 32'd0);
        chk("rst_ack", 32'(bus.swap_ack), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("rst_disp_top", 32'(bus.disp_top), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_wr_ready", 32'(bus.wr_ready), 32'd1);

        // Isolation: front=0 -> writes land in bank1
        wr(11'h005, 12'h111);
        wr(11'h405, 12'h222);
        do_swap(1'b0, 1'b1);
        // front=1 -> writes land in bank0; display still shows bank1
        wr(11'h005, 12'hABC);
        wr(11'h405, 12'hDEF);
        rd_chk("iso_b1", 10'd5, 12'h111, 12'h222);
        do_swap(1'b0, 1'b0);
        rd_chk("iso_b0", 10'd5, 12'hABC, 12'hDEF);

        // Deferred swap from row 7
        bus.row_sel  = 4'd7;
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
        chk("pend_busy", 32'(bus.busy), 32'd1);
        for (int r = 8; r <= 15; r++) begin
            bus.row_sel = 4'(r);
            step();
            chk("pend_wr_ready", 32'(bus.wr_ready), 32'd0);
            chk("pend_no_ack", 32'(bus.swap_ack), 32'd0);
        end
        chk("pend_front_hold", 32'(bus.front), 32'd0);
        bus.row_sel = 4'd0;
        step();
        chk("def_ack", 32'(bus.swap_ack), 32'd1);
        chk("def_front", 32'(bus.front), 32'd1);
        chk("def_wr_ready", 32'(bus.wr_ready), 32'd1);
        bus.row_sel = 4'd1;
        step();
        chk("def_ack_pulse", 32'(bus.swap_ack), 32'd0);
        rd_chk("def_rd", 10'd5, 12'h111, 12'h222);

        // Clear: front=1, fill bank0 corners, show them, then clear bank0
        wr(11'h000, 12'h5A5);
        wr(11'h3FF, 12'h777);
        wr(11'h400, 12'h333);
        wr(11'h7FF, 12'h444);
        do_swap(1'b0, 1'b0);
        rd_chk("pre_clr_a0", 10'd0, 12'h5A5, 12'h333);
        rd_chk("pre_clr_a1023", 10'd1023, 12'h777, 12'h444);
        do_swap(1'b1, 1'b1);
        chk("clr_busy", 32'(bus.busy), 32'd1);
        chk("clr_wr_ready", 32'(bus.wr_ready), 32'd0);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 2000) begin
            cnt++;
            step();
        end
        chk("clr_cycles", 32'(cnt), 32'd1024);
        chk("clr_done_wr_ready", 32'(bus.wr_ready), 32'd1);
        rd_chk("clr_b1_intact", 10'd5, 12'h111, 12'h222);
        do_swap(1'b0, 1'b0);
        rd_chk("clr_a0", 10'd0, 12'h000, 12'h000);
        rd_chk("clr_a1023", 10'd1023, 12'h000, 12'h000);
        rd_chk("clr_a5", 10'd5, 12'h000, 12'h000);

        // swap_req on the wrap cycle: no swap this frame
        bus.row_sel = 4'd15;
        step();
        bus.row_sel  = 4'd0;
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
        chk("sim_no_ack", 32'(bus.swap_ack), 32'd0);
        chk("sim_front", 32'(bus.front), 32'd0);
        chk("sim_busy", 32'(bus.busy), 32'd1);
        bus.row_sel  = 4'd1;
        step();
        bus.swap_req = 1'b1;    // ignored in SWAP_PEND
        step();
        bus.swap_req = 1'b0;
        bus.row_sel  = 4'd15;
        step();
        bus.row_sel = 4'd0;
        step();
        chk("sim_ack", 32'(bus.swap_ack), 32'd1);
        chk("sim_front_tog", 32'(bus.front), 32'd1);
        bus.row_sel = 4'd1;
        step();
        chk("sim_idle", 32'(bus.busy), 32'd0);
        bus.row_sel = 4'd15;
        step();
        bus.row_sel = 4'd0;
        step();
        chk("sim_one_toggle_ack", 32'(bus.swap_ack), 32'd0);
        chk("sim_one_toggle_front", 32'(bus.front), 32'd1);
        bus.row_sel = 4'd1;
        step();

        // Reset mid-clear at clear_addr=300
        do_swap(1'b1, 1'b0);
        repeat (300) step();
        chk("mid_clr_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step();
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_front", 32'(bus.front), 32'd0);
        chk("mrst_ack", 32'(bus.swap_ack), 32'd0);
        chk("mrst_wr_ready", 32'(bus.wr_ready), 32'd0);
        rst = 1'b0;
        step();
        chk("mrst_rel_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("mrst_rel_busy", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
